// File: rtl/riscv_mdu_iter_if.sv
// Issue/write-back bundle between the control unit and the iterative MDU.
// The CPU side drives issue and abort; the MDU drives status and write-back.
interface riscv_mdu_iter_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wt_addr;
    logic        reg_write;

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_addr, kill,
        output busy, done, result, wt_addr, reg_write
    );

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_addr, kill,
        input  busy, done, result, wt_addr, reg_write
    );
endinterface

// File: rtl/riscv_mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier and
// restoring divider on magnitudes, with sign correction and the RV32M
// divide-by-zero / signed-overflow results applied at the end.
module riscv_mdu_iter #(
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_mdu_iter_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e      state_q, state_d;

    // Latched issue operands, held for the whole operation.
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;

    // Iteration datapath: opa_q is the left-shifting multiplicand / dividend
    // source, opb_q the right-shifting multiplier or the fixed divisor.
    logic [63:0] opa_q;
    logic [31:0] opb_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;

    logic [31:0] result_q;
    logic [4:0]  wt_addr_q;

    logic        accept;
    logic        is_div;
    logic        a_signed_op, b_signed_op;
    logic        a_neg, b_neg;
    logic        div_zero, div_ovf, special;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic [63:0] acc_step;
    logic [63:0] prod;
    logic [31:0] quo_s, rem_s;
    logic [31:0] fix_res;

    assign accept = (state_q == IDLE) && bus.start && !bus.kill;
    assign is_div = op_q[2];

    // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed.
    assign a_signed_op = (op_q == 3'b001) || (op_q == 3'b010) ||
                         (op_q == 3'b100) || (op_q == 3'b110);
    assign b_signed_op = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    assign a_neg       = a_signed_op && a_q[31];
    assign b_neg       = b_signed_op && b_q[31];

    assign div_zero = is_div && (b_q == 32'd0);
    assign div_ovf  = is_div && !op_q[0] && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign special  = div_zero || div_ovf;

    // One iteration step: restoring-divide trial subtract or shift-add multiply.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        acc_step = acc_q;
        rem_sh   = {acc_q[63:32], opa_q[31]};
        diff     = {1'b0, rem_sh} - {2'b00, opb_q};
        if (is_div) begin
            if (!diff[33]) begin
                acc_step = {diff[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_step = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end
        end else if (opb_q[0]) begin
            acc_step = acc_q + opa_q;
        end
    end

    // Sign correction and result selection, including the fixed special results.
    always_comb begin
        prod    = (a_neg ^ b_neg) ? -acc_q : acc_q;
        quo_s   = (a_neg ^ b_neg) ? -acc_q[31:0] : acc_q[31:0];
        rem_s   = a_neg ? -acc_q[63:32] : acc_q[63:32];
        fix_res = 32'd0;
        case (op_q)
            3'b000:                 fix_res = prod[31:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[63:32];
            3'b100, 3'b101: begin
                if (div_zero)     fix_res = 32'hFFFF_FFFF;
                else if (div_ovf) fix_res = 32'h8000_0000;
                else              fix_res = quo_s;
            end
            default: begin
                if (div_zero)     fix_res = a_q;
                else if (div_ovf) fix_res = 32'd0;
                else              fix_res = rem_s;
            end
        endcase
    end

    // Next-state logic; kill returns to IDLE from anywhere and wins over start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = PREP;
            PREP: state_d = (EARLY_SPECIAL && special) ? FIX : CALC;
            CALC: if (cnt_q == 5'd31) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill) begin
            state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand latch, iteration datapath and write-back registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rd_q      <= 5'd0;
            opa_q     <= 64'd0;
            opb_q     <= 32'd0;
            acc_q     <= 64'd0;
            cnt_q     <= 5'd0;
            result_q  <= 32'd0;
            wt_addr_q <= 5'd0;
        end else begin
            if (accept) begin
                op_q <= bus.funct3;
                a_q  <= bus.rs1_data;
                b_q  <= bus.rs2_data;
                rd_q <= bus.rd_addr;
            end
            case (state_q)
                PREP: begin
                    opa_q <= {32'd0, (a_neg ? -a_q : a_q)};
                    opb_q <= b_neg ? -b_q : b_q;
                    acc_q <= 64'd0;
                    cnt_q <= 5'd0;
                end
                CALC: begin
                    acc_q <= acc_step;
                    opa_q <= opa_q << 1;
                    if (!is_div) opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + 5'd1;
                end
                FIX: begin
                    if (!bus.kill) begin
                        result_q  <= fix_res;
                        wt_addr_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.wt_addr   = wt_addr_q;
    assign bus.reg_write = bus.done && (wt_addr_q != 5'd0);

endmodule

// File: doc/riscv_mdu_iter.md
# riscv_mdu_iter

Iterative RV32M multiply/divide unit for the multi-cycle CPU datapath. It takes operands from the register-file read ports (Rs1_data/Rs2_data) when an M-extension instruction issues. It computes the result with a 32-step shift-add multiplier or restoring divider and presents a write-back triple (result, wt_addr, reg_write) that drives the register-file write port. The control unit stalls on busy; the interrupt path aborts an operation in flight through kill.

## Interface
- EARLY_SPECIAL, default 1: 1 = divide-by-zero and signed overflow bypass the iteration loop; 0 = they run the full loop with a fixed result substituted.
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  issue request; accepted only when state is IDLE and kill=0
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  32  operand A (multiplicand/dividend)
- rs2_data  in  32  operand B (multiplier/divisor)
- rd_addr  in  5  destination register
- kill  in  1  synchronous abort (trap/flush)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- result  out  32  registered result; holds until the next completion
- wt_addr  out  5  registered rd_addr of the completed op
- reg_write  out  1  done && (wt_addr != 0)

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE→PREP on start && !kill. Latch funct3, rs1_data, rs2_data, rd_addr. Inputs are don't-care after the accepting edge.
- PREP:
  - Compute operand signs: MULH, DIV and REM are signed on both operands; MULHSU is signed on A only; all others are unsigned.
  - Load magnitudes and clear the 64-bit accumulator and the 5-bit counter.
  - If EARLY_SPECIAL and the op is special, go to FIX; otherwise go to CALC.
- CALC, one step per edge, counter 0..31:
  - Multiply: add the shifted multiplicand when the multiplier bit is 1.
  - Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit.
  - Leave to FIX on the edge where counter==31.
- FIX: apply sign correction, select the output, register result/wt_addr, then go to DONE.
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the product.
  - Product is negated when the operand signs differ.
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A).
- Special cases (independent of EARLY_SPECIAL):
  - B==0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = A.
  - A==0x80000000, B==0xFFFFFFFF: DIV = 0x80000000; REM = 0.
- DONE: done=1, then go to IDLE.
- kill: from any state, go to IDLE on the next edge. done, result and wt_addr are not updated. kill overrides start in the same cycle.
- start while busy is ignored (no queueing).

## Timing
- The accepting edge is E0.
- Normal path:
  - PREP after E0, CALC after E1. Counter steps on E2..E33.
  - FIX after E33. result/wt_addr register on E34.
  - done=1 for the cycle after E34. IDLE after E35.
- Special path with EARLY_SPECIAL=1: FIX after E1, done for the cycle after E2, IDLE after E3.
- busy is high from E0 through E35 (E3 on the early path). A new start is accepted in the first IDLE cycle: back-to-back throughput is 36 cycles.
- Reset values: state IDLE, busy 0, done 0, reg_write 0, result 0x00000000, wt_addr 0, counter 0.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values and no done.

## Test plan
- MUL A=7, B=0xFFFFFFFD (−3), rd=5:
  - result 0xFFFFFFEB on E34, done pulse on that cycle only.
  - wt_addr 5, reg_write 1, busy low after E35.
- MULH A=B=0x80000000 → 0x40000000.
- MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU A=100, B=7 → 14. REMU on the same operands → 2.
- DIVU B=0 → 0xFFFFFFFF; REMU A=0x1234, B=0 → 0x1234. With EARLY_SPECIAL=1, done follows E2.
- DIV A=0x80000000, B=−1 → 0x80000000; REM on the same operands → 0. Repeat with EARLY_SPECIAL=0: same values, done follows E34.
- kill at E10:
  - No done pulse; busy low after E11; result keeps its old value.
  - start in the same cycle as kill in IDLE is ignored.
  - A new start on the next cycle completes normally.
- rd_addr=0: done pulses but reg_write stays 0.
- rst asserted mid-CALC: outputs go to reset values without a clock edge.
